// File: rtl/hex_parser.sv
// hex_parser: turns a stream of ASCII bytes into binary values, one hex
// token at a time. A token is a run of hex digits (0-9, a-f, A-F) closed
// by a terminator (space, tab, CR, LF or ','). Other bytes cause an error.
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   in_valid/in_data one ASCII byte per strobed cycle (always ready)
//   out_valid        one-cycle strobe: a token completed
//   out_value        parsed value, held until the next out_valid
//   out_digits       digit count of that token, held with out_value
//   out_term         terminator byte that closed it, held with out_value
//   error            one-cycle strobe: bad character or digit overflow
//   busy             a token is being accumulated or discarded
module hex_parser #(
  parameter int BITS   = 32,
  parameter int DIGITS = BITS / 4,
  parameter int CW     = $clog2(DIGITS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            out_valid,
  output logic [BITS-1:0] out_value,
  output logic [CW-1:0]   out_digits,
  output logic [7:0]      out_term,
  output logic            error,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIGITS,
    S_SKIP
  } state_e;

  localparam logic [CW-1:0] MAXC = CW'(DIGITS);

  state_e          state_q, state_d;
  logic [BITS-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ov_q, ov_d;
  logic            err_q, err_d;
  logic [BITS-1:0] val_q, val_d;
  logic [CW-1:0]   dig_q, dig_d;
  logic [7:0]      term_q, term_d;

  logic       is_dig;
  logic       is_term;
  logic [3:0] nib;

  // Letters a-f / A-F share low nibbles 1..6, so +9 gives 10..15.
  always_comb begin
    is_dig  = 1'b0;
    nib     = 4'h0;
    if (in_data >= 8'h30 && in_data <= 8'h39) begin
      is_dig = 1'b1;
      nib    = in_data[3:0];
    end else if ((in_data >= 8'h41 && in_data <= 8'h46) ||
                 (in_data >= 8'h61 && in_data <= 8'h66)) begin
      is_dig = 1'b1;
      nib    = in_data[3:0] + 4'd9;
    end
    is_term = (in_data == 8'h20) || (in_data == 8'h09) ||
              (in_data == 8'h0D) || (in_data == 8'h0A) ||
              (in_data == 8'h2C);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ov_d    = 1'b0;
    err_d   = 1'b0;
    val_d   = val_q;
    dig_d   = dig_q;
    term_d  = term_q;
    if (in_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_dig) begin
            acc_d   = BITS'(nib);
            cnt_d   = CW'(1);
            state_d = S_DIGITS;
          end else if (!is_term) begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_DIGITS: begin
          if (is_dig) begin
            if (cnt_q == MAXC) begin
              err_d   = 1'b1;
              state_d = S_SKIP;
            end else begin
              acc_d = (acc_q << 4) | BITS'(nib);
              cnt_d = cnt_q + CW'(1);
            end
          end else if (is_term) begin
            val_d   = acc_q;
            dig_d   = cnt_q;
            term_d  = in_data;
            ov_d    = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_SKIP: begin
          // Partial accumulator is cleared on exit so IDLE restarts clean.
          if (is_term) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      val_q   <= '0;
      dig_q   <= '0;
      term_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      val_q   <= val_d;
      dig_q   <= dig_d;
      term_q  <= term_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_value  = val_q;
  assign out_digits = dig_q;
  assign out_term   = term_q;
  assign error      = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_hex_parser.sv
// tb_hex_parser: table-driven directed vectors for hex_parser plus a
// hand-written asynchronous reset-mid-token sequence.
module tb_hex_parser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic [31:0] out_value;
  logic [3:0]  out_digits;
  logic [7:0]  out_term;
  logic        error;
  logic        busy;

  int errors = 0;
  int checks = 0;

  hex_parser dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_value  (out_value),
    .out_digits (out_digits),
    .out_term   (out_term),
    .error      (error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        ov;
    logic        er;
    logic        bz;
    logic [31:0] val;
    logic [3:0]  dig;
    logic [7:0]  term;
  } vec_t;

  vec_t vq[$];

  logic [31:0] e_val = '0;
  logic [3:0]  e_dig = '0;
  logic [7:0]  e_term = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp, input int idx);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input logic ov, input logic er,
                         input logic bz, input int idx);
    chk("out_valid", 32'(out_valid), 32'(ov), idx);
    chk("error", 32'(error), 32'(er), idx);
    chk("busy", 32'(busy), 32'(bz), idx);
    chk("out_value", out_value, e_val, idx);
    chk("out_digits", 32'(out_digits), 32'(e_dig), idx);
    chk("out_term", 32'(out_term), 32'(e_term), idx);
  endtask

  // byte with no strobe expected
  function automatic void b(input logic [7:0] d, input logic er,
                            input logic bz);
    vq.push_back('{1'b1, d, 1'b0, er, bz, 32'h0, 4'h0, 8'h0});
  endfunction

  // idle cycle
  function automatic void g(input logic bz);
    vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, bz, 32'h0, 4'h0, 8'h0});
  endfunction

  // terminator producing a strobe
  function automatic void t(input logic [7:0] d, input logic [31:0] val,
                            input logic [3:0] dig);
    vq.push_back('{1'b1, d, 1'b1, 1'b0, 1'b0, val, dig, d});
  endfunction

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // "1a2B\n"
    b("1", 0, 1); b("a", 0, 1); b("2", 0, 1); b("B", 0, 1);
    t(8'h0A, 32'h00001A2B, 4'd4);
    g(0);
    // "  ff ," with gaps
    b(" ", 0, 0); g(0); b(" ", 0, 0); g(0);
    b("f", 0, 1); g(1); b("f", 0, 1); g(1);
    t(8'h20, 32'h000000FF, 4'd2);
    g(0); b(",", 0, 0);
    // "123456789 7\n": overflow on the 9th digit
    b("1", 0, 1); b("2", 0, 1); b("3", 0, 1); b("4", 0, 1);
    b("5", 0, 1); b("6", 0, 1); b("7", 0, 1); b("8", 0, 1);
    b("9", 1, 1); b(" ", 0, 0);
    b("7", 0, 1); t(8'h0A, 32'h00000007, 4'd1);
    // "12g4\r5 "
    b("1", 0, 1); b("2", 0, 1); b("g", 1, 1); b("4", 0, 1);
    b(8'h0D, 0, 0);
    b("5", 0, 1); t(8'h20, 32'h00000005, 4'd1);
    // exactly DIGITS digits, tab terminator
    b("F", 0, 1); b("e", 0, 1); b("D", 0, 1); b("c", 0, 1);
    b("0", 0, 1); b("9", 0, 1); b("A", 0, 1); b("f", 0, 1);
    t(8'h09, 32'hFEDC09AF, 4'd8);
    // out-of-class bytes just outside the digit ranges, from IDLE
    b(":", 1, 1); b("@", 0, 1); b(",", 0, 0);
    b("G", 1, 1); b(8'h0A, 0, 0);
    // "1 2 " back to back
    b("1", 0, 1); t(8'h20, 32'h00000001, 4'd1);
    b("2", 0, 1); t(8'h20, 32'h00000002, 4'd1);
    g(0);

    #12;
    chk_all(0, 0, 0, -1);
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[i]) begin
      step(vq[i].v, vq[i].d);
      if (vq[i].ov) begin
        e_val  = vq[i].val;
        e_dig  = vq[i].dig;
        e_term = vq[i].term;
      end
      chk_all(vq[i].ov, vq[i].er, vq[i].bz, i);
    end

    // "abc" then asynchronous reset between edges
    step(1'b1, "a");
    step(1'b1, "b");
    step(1'b1, "c");
    chk("busy_pre_rst", 32'(busy), 32'd1, 900);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    e_val = '0; e_dig = '0; e_term = '0;
    chk_all(0, 0, 0, 901);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, "d");
    chk_all(0, 0, 1, 902);
    step(1'b1, 8'h0A);
    e_val = 32'h0000000D; e_dig = 4'd1; e_term = 8'h0A;
    chk_all(1, 0, 0, 903);
    step(1'b0, 8'h00);
    chk_all(0, 0, 0, 904);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
